// File: rtl/rdptr_h_lvl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rdptr_h_lvl_pkg
// Description : Shared pointer types, depth constant and Gray/binary helpers
//               for both the read and the write pointer handlers.
// Revision    : 1.0 - initial release
// ============================================================================
package rdptr_h_lvl_pkg;

  localparam int PKG_PTR_WIDTH = 3;
  localparam int FIFO_DEPTH    = 2 ** PKG_PTR_WIDTH;

  // One extra bit beyond the address distinguishes full from empty.
  typedef logic [PKG_PTR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[PKG_PTR_WIDTH] = gray[PKG_PTR_WIDTH];
    for (int i = PKG_PTR_WIDTH - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage : rdptr_h_lvl_pkg
`default_nettype wire

// File: rtl/rdptr_h_lvl_if.sv
`default_nettype none
// ============================================================================
// Module      : rdptr_h_lvl_if
// Description : Read-pointer handler bus: read request, synchronized Gray
//               write pointer in; pointers and status flags out. The level
//               and almost-empty signals exist only when RDPTR_LEVEL_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rdptr_h_lvl_if #(
  parameter int PTR_WIDTH = 3
);
  logic                 rd_en;
  logic [PTR_WIDTH:0]   g_wrptr_sync;
  logic [PTR_WIDTH:0]   b_rdptr;
  logic [PTR_WIDTH:0]   g_rdptr;
  logic                 fifo_empty;
  logic                 underflow;
`ifdef RDPTR_LEVEL_EN
  logic [PTR_WIDTH:0]   rd_level;
  logic                 almost_empty;
`endif

  // Requester side: issues reads and supplies the synchronized write pointer.
  modport master (
    output rd_en,
    output g_wrptr_sync,
    input  b_rdptr,
    input  g_rdptr,
    input  fifo_empty,
`ifdef RDPTR_LEVEL_EN
    input  rd_level,
    input  almost_empty,
`endif
    input  underflow
  );

  // Pointer handler side.
  modport slave (
    input  rd_en,
    input  g_wrptr_sync,
    output b_rdptr,
    output g_rdptr,
    output fifo_empty,
`ifdef RDPTR_LEVEL_EN
    output rd_level,
    output almost_empty,
`endif
    output underflow
  );

endinterface : rdptr_h_lvl_if
`default_nettype wire

// File: rtl/rdptr_h_lvl_gray2bin_conv.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin_conv
// Description : Parameterized Gray-to-binary converter. Each binary bit is
//               the XOR of all Gray bits at and above its position.
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] i_gray,
  output logic      [WIDTH-1:0] o_bin
);

  // XOR-prefix from the MSB down to each bit position.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule : gray2bin_conv
`default_nettype wire

// File: rtl/rdptr_h_lvl.sv
`default_nettype none
// ============================================================================
// Module      : rdptr_h_lvl
// Description : Read-side pointer handler for the dual-clock FIFO. Advances
//               binary/Gray read pointers on accepted reads, registers the
//               empty flag and a sticky underflow flag. With RDPTR_LEVEL_EN
//               defined it also registers the fill level and almost_empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rdptr_h_lvl
  import rdptr_h_lvl_pkg::*;
#(
  parameter int PTR_WIDTH = PKG_PTR_WIDTH,
  parameter int AE_THRESH = 1
) (
  input  wire logic      rdclk,
  input  wire logic      rdrst,
  rdptr_h_lvl_if.slave   bus
);

  logic [PTR_WIDTH:0] r_b_rdptr;
  logic [PTR_WIDTH:0] r_g_rdptr;
  logic               r_fifo_empty;
  logic               r_underflow;

  logic               w_accept;
  logic [PTR_WIDTH:0] w_b_rdptr_next;
  logic [PTR_WIDTH:0] w_g_rdptr_next;

  // A read is only accepted while not empty; dropped requests leave the
  // pointers alone. All flags are derived from the post-read pointer so that
  // empty asserts on the very edge the last entry is consumed.
  always_comb begin
    w_accept       = bus.rd_en & ~r_fifo_empty;
    w_b_rdptr_next = r_b_rdptr + {{PTR_WIDTH{1'b0}}, w_accept};
    w_g_rdptr_next = (w_b_rdptr_next >> 1) ^ w_b_rdptr_next;
  end

  // Pointer, empty and underflow registers; reset wins over any read request.
  always_ff @(posedge rdclk) begin
    if (rdrst) begin
      r_b_rdptr    <= '0;
      r_g_rdptr    <= '0;
      r_fifo_empty <= 1'b1;
      r_underflow  <= 1'b0;
    end else begin
      r_b_rdptr    <= w_b_rdptr_next;
      r_g_rdptr    <= w_g_rdptr_next;
      r_fifo_empty <= (w_g_rdptr_next == bus.g_wrptr_sync);
      r_underflow  <= r_underflow | (bus.rd_en & r_fifo_empty);
    end
  end

  assign bus.b_rdptr    = r_b_rdptr;
  assign bus.g_rdptr    = r_g_rdptr;
  assign bus.fifo_empty = r_fifo_empty;
  assign bus.underflow  = r_underflow;

`ifdef RDPTR_LEVEL_EN
  localparam logic [PTR_WIDTH:0] C_AE_THRESH = (PTR_WIDTH+1)'(AE_THRESH);

  logic [PTR_WIDTH:0] w_b_wrptr_sync;
  logic [PTR_WIDTH:0] w_level_next;
  logic [PTR_WIDTH:0] r_rd_level;
  logic               r_almost_empty;

  gray2bin_conv #(
    .WIDTH (PTR_WIDTH + 1)
  ) u_gray2bin_conv (
    .i_gray (bus.g_wrptr_sync),
    .o_bin  (w_b_wrptr_sync)
  );

  // Occupancy wraps naturally in PTR_WIDTH+1 bits; full reads as FIFO_DEPTH.
  always_comb begin
    w_level_next = w_b_wrptr_sync - w_b_rdptr_next;
  end

  // Level and almost_empty share the edge on which fifo_empty updates.
  always_ff @(posedge rdclk) begin
    if (rdrst) begin
      r_rd_level     <= '0;
      r_almost_empty <= 1'b1;
    end else begin
      r_rd_level     <= w_level_next;
      r_almost_empty <= (w_level_next <= C_AE_THRESH);
    end
  end

  assign bus.rd_level     = r_rd_level;
  assign bus.almost_empty = r_almost_empty;
`endif

endmodule : rdptr_h_lvl
`default_nettype wire

// File: tb/tb_rdptr_h_lvl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rdptr_h_lvl
// Description : Self-checking bench for rdptr_h_lvl (PTR_WIDTH=3,
//               AE_THRESH=1). Level checks apply when RDPTR_LEVEL_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rdptr_h_lvl;
  import rdptr_h_lvl_pkg::*;

  typedef struct {
    logic       rst;
    logic       rd;
    logic [3:0] gw;
    logic [3:0] b;
    logic [3:0] g;
    logic       e;
    logic       uf;
    logic [3:0] lvl;
    logic       ae;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vec_t vecs[$];
  vec_t sb[$];

  rdptr_h_lvl_if #(.PTR_WIDTH(3)) bus ();

  rdptr_h_lvl #(
    .PTR_WIDTH (3),
    .AE_THRESH (1)
  ) u_dut (
    .rdclk (clk),
    .rdrst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic rd, input logic [3:0] gw,
                              input logic [3:0] b, input logic [3:0] g,
                              input logic e, input logic uf,
                              input logic [3:0] lvl, input logic ae);
    vec_t v;
    v.rst = r; v.rd = rd; v.gw = gw; v.b = b; v.g = g;
    v.e = e; v.uf = uf; v.lvl = lvl; v.ae = ae;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one step, queue its expectation, and score it after the edge.
  task automatic step(input vec_t v, input int idx);
    vec_t x;
    @(negedge clk);
    rst              = v.rst;
    bus.rd_en        = v.rd;
    bus.g_wrptr_sync = v.gw;
    sb.push_back(v);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("b_rdptr",    idx, 32'(bus.b_rdptr),    32'(x.b));
    chk("g_rdptr",    idx, 32'(bus.g_rdptr),    32'(x.g));
    chk("fifo_empty", idx, 32'(bus.fifo_empty), 32'(x.e));
    chk("underflow",  idx, 32'(bus.underflow),  32'(x.uf));
`ifdef RDPTR_LEVEL_EN
    chk("rd_level",     idx, 32'(bus.rd_level),     32'(x.lvl));
    chk("almost_empty", idx, 32'(bus.almost_empty), 32'(x.ae));
`endif
  endtask

  initial begin
    ptr_t m_b, m_w, nb, lvl;
    logic m_e, m_uf, rd, acc;

    bus.rd_en        = 1'b1;
    bus.g_wrptr_sync = '0;

    //             rst rd gw      b      g      e  uf lvl    ae
    // reset held with rd_en high
    vecs.push_back(mk(1, 1, 4'h0, 4'd0, 4'h0, 1, 0, 4'd0, 1));
    vecs.push_back(mk(1, 1, 4'h0, 4'd0, 4'h0, 1, 0, 4'd0, 1));
    // underflow on empty, sticky afterwards
    vecs.push_back(mk(0, 1, 4'h0, 4'd0, 4'h0, 1, 1, 4'd0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 4'd0, 4'h0, 1, 1, 4'd0, 1));
    // drain: write pointer at 4 (Gray 0110)
    vecs.push_back(mk(0, 0, 4'h6, 4'd0, 4'h0, 0, 1, 4'd4, 0));
    vecs.push_back(mk(0, 1, 4'h6, 4'd1, 4'h1, 0, 1, 4'd3, 0));
    vecs.push_back(mk(0, 1, 4'h6, 4'd2, 4'h3, 0, 1, 4'd2, 0));
    vecs.push_back(mk(0, 1, 4'h6, 4'd3, 4'h2, 0, 1, 4'd1, 1));
    vecs.push_back(mk(0, 1, 4'h6, 4'd4, 4'h6, 1, 1, 4'd0, 1));
    vecs.push_back(mk(0, 1, 4'h6, 4'd4, 4'h6, 1, 1, 4'd0, 1));
    // full/wrap: write pointer at 8 (Gray 1100)
    vecs.push_back(mk(1, 0, 4'h0, 4'd0, 4'h0, 1, 0, 4'd0, 1));
    vecs.push_back(mk(0, 0, 4'hC, 4'd0, 4'h0, 0, 0, 4'd8, 0));
    vecs.push_back(mk(0, 1, 4'hC, 4'd1, 4'h1, 0, 0, 4'd7, 0));
    vecs.push_back(mk(0, 1, 4'hC, 4'd2, 4'h3, 0, 0, 4'd6, 0));
    vecs.push_back(mk(0, 1, 4'hC, 4'd3, 4'h2, 0, 0, 4'd5, 0));
    vecs.push_back(mk(0, 1, 4'hC, 4'd4, 4'h6, 0, 0, 4'd4, 0));
    vecs.push_back(mk(0, 1, 4'hC, 4'd5, 4'h7, 0, 0, 4'd3, 0));
    vecs.push_back(mk(0, 1, 4'hC, 4'd6, 4'h5, 0, 0, 4'd2, 0));
    vecs.push_back(mk(0, 1, 4'hC, 4'd7, 4'h4, 0, 0, 4'd1, 1));
    vecs.push_back(mk(0, 1, 4'hC, 4'd8, 4'hC, 1, 0, 4'd0, 1));
    vecs.push_back(mk(0, 0, 4'hD, 4'd8, 4'hC, 0, 0, 4'd1, 1));
    vecs.push_back(mk(0, 1, 4'hD, 4'd9, 4'hD, 1, 0, 4'd0, 1));
    // level 5 (write pointer 14 = Gray 1001), then reset with rd_en high
    vecs.push_back(mk(0, 0, 4'h9, 4'd9, 4'hD, 0, 0, 4'd5, 0));
    vecs.push_back(mk(1, 1, 4'h9, 4'd0, 4'h0, 1, 0, 4'd0, 1));
    // drain again from a clean underflow flag
    vecs.push_back(mk(1, 0, 4'h0, 4'd0, 4'h0, 1, 0, 4'd0, 1));
    vecs.push_back(mk(0, 0, 4'h6, 4'd0, 4'h0, 0, 0, 4'd4, 0));
    vecs.push_back(mk(0, 1, 4'h6, 4'd1, 4'h1, 0, 0, 4'd3, 0));
    vecs.push_back(mk(0, 1, 4'h6, 4'd2, 4'h3, 0, 0, 4'd2, 0));
    vecs.push_back(mk(0, 1, 4'h6, 4'd3, 4'h2, 0, 0, 4'd1, 1));
    vecs.push_back(mk(0, 1, 4'h6, 4'd4, 4'h6, 1, 0, 4'd0, 1));
    vecs.push_back(mk(0, 1, 4'h6, 4'd4, 4'h6, 1, 1, 4'd0, 1));
    // write pointer moves while a read is requested on empty: dropped
    vecs.push_back(mk(0, 1, 4'h7, 4'd4, 4'h6, 0, 1, 4'd1, 1));
    // read accepted on the same edge the write pointer advances
    vecs.push_back(mk(0, 1, 4'h5, 4'd5, 4'h7, 0, 1, 4'd1, 1));
    vecs.push_back(mk(0, 1, 4'h5, 4'd6, 4'h5, 1, 1, 4'd0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Random traffic against a binary-count reference model.
    step(mk(1, 0, 4'h0, 4'd0, 4'h0, 1, 0, 4'd0, 1), 1000);
    m_b = '0; m_w = '0; m_e = 1'b1; m_uf = 1'b0;
    for (int c = 0; c < 300; c++) begin
      rd = 1'($urandom_range(0, 1));
      if (ptr_t'(m_w - m_b) < ptr_t'(FIFO_DEPTH) && $urandom_range(0, 1) == 1)
        m_w = m_w + 1'b1;
      acc  = rd & ~m_e;
      m_uf = m_uf | (rd & m_e);
      nb   = m_b + {3'b000, acc};
      lvl  = m_w - nb;
      m_e  = (nb == m_w);
      m_b  = nb;
      step(mk(0, rd, bin2gray(m_w), m_b, bin2gray(m_b), m_e, m_uf, lvl,
              (lvl <= 4'd1)), 2000 + c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rdptr_h_lvl
`default_nettype wire

// File: doc/rdptr_h_lvl.md
# rdptr_h_lvl

Read-side pointer handler for the dual-clock FIFO, sitting in the read clock domain directly opposite the write pointer handler. It advances the binary and Gray read pointers on accepted reads and derives a registered empty flag from the synchronized Gray write pointer. It also provides a registered fill level, an almost-empty flag and a sticky underflow flag. Its binary pointer addresses the FIFO memory read port, and its Gray pointer feeds the read-to-write synchronizer.

## Interface
- PTR_WIDTH, 3: address bits. Depth is 2^PTR_WIDTH. Pointers are PTR_WIDTH+1 bits.
- AE_THRESH, 1: almost_empty asserts when the level is less than or equal to this value. Legal range is 0..2^PTR_WIDTH.

- rdclk, in, 1: read-domain clock. This is the only clock.
- rdrst, in, 1: synchronous, active-high reset.
- rd_en, in, 1: read request.
- g_wrptr_sync, in, PTR_WIDTH+1: Gray write pointer, already synchronized into rdclk.
- b_rdptr, out, PTR_WIDTH+1: binary read pointer. Bits [PTR_WIDTH-1:0] form the memory read address.
- g_rdptr, out, PTR_WIDTH+1: Gray read pointer, sent to the synchronizer.
- fifo_empty, out, 1: registered empty flag.
- underflow, out, 1: sticky flag, set when rd_en is asserted while fifo_empty=1.
- rd_level, out, PTR_WIDTH+1: registered occupancy. Present only with the configuration macro.
- almost_empty, out, 1: registered flag. Present only with the configuration macro.

## Operation
- A read is accepted when `rd_en & !fifo_empty`.
  - b_rdptr_next = b_rdptr + accept, computed modulo 2^(PTR_WIDTH+1).
  - g_rdptr_next = (b_rdptr_next >> 1) ^ b_rdptr_next.
- All outputs are registered on the rising edge of rdclk. Each next value is computed from the _next pointer, not the current one.
  - fifo_empty <= (g_rdptr_next == g_wrptr_sync).
  - b_wrptr_sync = gray2bin(g_wrptr_sync), computed combinationally.
  - rd_level <= (b_wrptr_sync - b_rdptr_next) mod 2^(PTR_WIDTH+1). Range is 0..2^PTR_WIDTH.
  - almost_empty <= (level_next <= AE_THRESH).
  - underflow <= underflow | (rd_en & fifo_empty).
- A request made while empty is dropped: the pointers hold and only the underflow flag records it.
- underflow is cleared only by rdrst.
- Wrap-around: the pointer MSB toggles every 2^PTR_WIDTH accepted reads. Empty compares all PTR_WIDTH+1 bits, so a full FIFO (level 2^PTR_WIDTH) never reads as empty.
- Simultaneous read and write-pointer change: the flags reflect the new g_wrptr_sync combined with the post-read pointer in the same edge.
- Reset values:
  - b_rdptr = 0, g_rdptr = 0, underflow = 0, rd_level = 0.
  - fifo_empty = 1, almost_empty = 1.
- rdrst overrides rd_en. Reset in mid-operation returns every output to its reset value on the next edge.

## Timing
- Read-to-pointer latency is 1 cycle. The memory samples the address b_rdptr. Data for an accepted read is taken from the address presented in the accept cycle.
- fifo_empty asserts on the same edge that the pointer reaches the write pointer. There is no extra cycle in which a further read could be accepted.
- fifo_empty deasserts 1 rdclk after g_wrptr_sync changes. The total delay after the write is the synchronizer depth plus 1. This is pessimistic by design.
- rd_level and almost_empty share the same edge as fifo_empty.

## Configuration
- RDPTR_LEVEL_EN defined: the rd_level and almost_empty ports, the gray2bin instance and the subtractor are compiled in.
- RDPTR_LEVEL_EN undefined: those ports and that logic are absent. Pointer, fifo_empty and underflow behaviour is bit-identical in both builds.

## Structure
- Shared package (also used by the write side):
  - ptr_t, typedef of PTR_WIDTH+1 bits.
  - bin2gray and gray2bin functions.
  - FIFO_DEPTH constant.
- One sub-module: gray2bin_conv, a parameterized XOR-prefix Gray-to-binary converter instanced on g_wrptr_sync. The synchronizer itself is outside this block.

## Test plan
All scenarios use PTR_WIDTH=3 and AE_THRESH=1.
- Reset: hold rdrst=1 for 2 cycles with rd_en=1 -> b_rdptr=0, g_rdptr=0, fifo_empty=1, rd_level=0, almost_empty=1, underflow=0.
- Underflow: after reset, with g_wrptr_sync=0, pulse rd_en for 1 cycle -> b_rdptr stays 0, underflow=1 on the next edge and stays 1 through later valid reads.
- Drain:
  - Set g_wrptr_sync=4'b0110 (binary 4) -> next edge gives fifo_empty=0, rd_level=4, almost_empty=0.
  - Apply 3 reads -> b_rdptr=3, g_rdptr=4'b0010, rd_level=1, almost_empty=1.
  - Apply a 4th read -> b_rdptr=4, g_rdptr=4'b0110, fifo_empty=1, rd_level=0.
  - Apply a 5th rd_en -> pointer holds, underflow=1.
- Full/wrap:
  - Set g_wrptr_sync=4'b1100 (binary 8) with b_rdptr=0 -> rd_level=8, fifo_empty=0.
  - Apply 8 reads -> b_rdptr=8, g_rdptr=4'b1100, fifo_empty=1.
  - Set g_wrptr_sync=4'b1101 -> rd_level=1. Apply 1 read -> b_rdptr=9, fifo_empty=1.
- Mid-operation reset: with rd_level=5, hold rd_en=1 and assert rdrst for 1 cycle -> all outputs take reset values on that edge, and no read is accepted in that cycle.
- Macro off: compile without RDPTR_LEVEL_EN and rerun the Drain scenario -> identical b_rdptr, g_rdptr, fifo_empty and underflow traces.
